// File: rtl/wb_slot_arbiter.sv
// Time-slotted Wishbone arbiter: SPI1 bridge and video fetch share the bus; the last slot belongs to the 6502.
// Optional WB_SLOT_ARBITER_ROUND_ROBIN_EN alternates the winner on simultaneous requests (default: video first).
module wb_slot_arbiter #(
  parameter int WB_ADDR_WIDTH = 17,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_SLOTS     = 8,
  parameter int CPU_SLOT      = 7,
  parameter int GUARD_SLOT    = 6
) (
  input  logic                                   wb_clock_i,
  input  logic                                   wb_reset_ni,
  output logic [WB_ADDR_WIDTH-1:0]               wb_addr_o,
  output logic [DATA_WIDTH-1:0]                  wb_data_o,
  output logic                                   wb_we_o,
  output logic                                   wb_cycle_o,
  output logic                                   wb_strobe_o,
  input  logic                                   wb_stall_i,
  input  logic                                   wb_ack_i,
  input  logic [WB_ADDR_WIDTH-1:0]               spi1_addr_i,
  input  logic [DATA_WIDTH-1:0]                  spi1_data_i,
  input  logic                                   spi1_we_i,
  input  logic                                   spi1_cycle_i,
  input  logic                                   spi1_strobe_i,
  output logic                                   spi1_stall_o,
  input  logic [WB_ADDR_WIDTH-1:0]               video_addr_i,
  input  logic [DATA_WIDTH-1:0]                  video_data_i,
  input  logic                                   video_we_i,
  input  logic                                   video_cycle_i,
  input  logic                                   video_strobe_i,
  output logic                                   video_stall_o,
  input  logic                                   clk8_en_i,
  output logic                                   cpu_grant_en_o,
  output logic                                   arb_overrun_o,
  output logic [$clog2(NUM_SLOTS)-1:0]           dbg_slot_o,
  output logic [1:0]                             dbg_state_o,
  output logic [7:0]                             dbg_ack_count_o
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPI   = 2'd1,
    ST_VIDEO = 2'd2,
    ST_CPU   = 2'd3
  } state_t;

  state_t            state_q;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;
  logic              slot_wrap;
  logic              enter_cpu;
  logic              grant_ok;
  logic              owner_cyc;
  logic              pick_video;

`ifdef WB_SLOT_ARBITER_ROUND_ROBIN_EN
  logic last_grant_video_q;
`endif

  always_comb begin
    slot_wrap = clk8_en_i && (slot_q == SLOT_W'(NUM_SLOTS - 1));
    slot_d    = slot_q;
    if (clk8_en_i) slot_d = slot_wrap ? '0 : slot_q + 1'b1;
    enter_cpu = clk8_en_i && (slot_d == SLOT_W'(CPU_SLOT));
    grant_ok  = (slot_q != SLOT_W'(GUARD_SLOT)) && (slot_q != SLOT_W'(CPU_SLOT));
    owner_cyc = (state_q == ST_SPI) ? spi1_cycle_i : video_cycle_i;
`ifdef WB_SLOT_ARBITER_ROUND_ROBIN_EN
    pick_video = video_cycle_i && (!spi1_cycle_i || !last_grant_video_q);
`else
    pick_video = video_cycle_i;
`endif
  end

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      slot_q          <= '0;
      state_q         <= ST_IDLE;
      cpu_grant_en_o  <= 1'b0;
      arb_overrun_o   <= 1'b0;
      dbg_ack_count_o <= '0;
`ifdef WB_SLOT_ARBITER_ROUND_ROBIN_EN
      last_grant_video_q <= 1'b1;
`endif
    end else begin
      slot_q         <= slot_d;
      cpu_grant_en_o <= 1'b0;
      if ((state_q == ST_SPI || state_q == ST_VIDEO) && wb_ack_i)
        dbg_ack_count_o <= dbg_ack_count_o + 8'd1;
      case (state_q)
        ST_IDLE: begin
          if (enter_cpu) begin
            state_q        <= ST_CPU;
            cpu_grant_en_o <= 1'b1;
          end else if (grant_ok && (spi1_cycle_i || video_cycle_i)) begin
            state_q <= pick_video ? ST_VIDEO : ST_SPI;
`ifdef WB_SLOT_ARBITER_ROUND_ROBIN_EN
            last_grant_video_q <= pick_video;
`endif
          end
        end
        ST_SPI, ST_VIDEO: begin
          // An owner that releases CYC on the very edge the CPU slot starts still yields a clean CPU slot.
          if (!owner_cyc) begin
            state_q        <= enter_cpu ? ST_CPU : ST_IDLE;
            cpu_grant_en_o <= enter_cpu;
          end else if (enter_cpu) begin
            arb_overrun_o <= 1'b1;
          end
        end
        ST_CPU: begin
          if (slot_wrap) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake: a master's transfer is accepted on a cycle where its cycle/strobe are high and its stall_o is
  // low; stall_o is forced high whenever that master does not own the bus.
  always_comb begin
    wb_addr_o     = '0;
    wb_data_o     = '0;
    wb_we_o       = 1'b0;
    wb_cycle_o    = 1'b0;
    wb_strobe_o   = 1'b0;
    spi1_stall_o  = 1'b1;
    video_stall_o = 1'b1;
    case (state_q)
      ST_SPI: begin
        wb_addr_o    = spi1_addr_i;
        wb_data_o    = spi1_data_i;
        wb_we_o      = spi1_we_i;
        wb_cycle_o   = spi1_cycle_i;
        wb_strobe_o  = spi1_strobe_i;
        spi1_stall_o = wb_stall_i;
      end
      ST_VIDEO: begin
        wb_addr_o     = video_addr_i;
        wb_data_o     = video_data_i;
        wb_we_o       = video_we_i;
        wb_cycle_o    = video_cycle_i;
        wb_strobe_o   = video_strobe_i;
        video_stall_o = wb_stall_i;
      end
      default: ;
    endcase
  end

  assign dbg_slot_o  = slot_q;
  assign dbg_state_o = state_q;

endmodule
